// File: rtl/simon_pkg.sv
// Shared sizing, types and mode-LED encodings for the Simon datapath and control blocks.
package simon_pkg;

  localparam int unsigned PATTERN_W = 4;
  localparam int unsigned DEPTH     = 64;
  localparam int unsigned ADDR_W    = 6;

  typedef logic [PATTERN_W-1:0] pattern_t;
  typedef logic [ADDR_W:0]      count_t;

  localparam logic [2:0] ModeInput    = 3'b001;
  localparam logic [2:0] ModePlayback = 3'b010;
  localparam logic [2:0] ModeRepeat   = 3'b100;
  localparam logic [2:0] ModeDone     = 3'b111;

endpackage

// File: rtl/simon_pattern_mem.sv
// DEPTH x PATTERN_W pattern register file: synchronous write, asynchronous read.
module simon_pattern_mem #(
  parameter int unsigned PATTERN_W = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [PATTERN_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [PATTERN_W-1:0] rdata
);

  logic [PATTERN_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; every read is qualified by n upstream.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon responder datapath: pattern memory, counters n and i, compares and LED mux.
// Define SIMON_ONEHOT_CHECK_EN to require one-hot switch patterns (otherwise any nonzero).
module simon_datapath
  import simon_pkg::*;
#(
  parameter int unsigned PATTERN_W = simon_pkg::PATTERN_W,
  parameter int unsigned DEPTH     = simon_pkg::DEPTH,
  parameter int unsigned ADDR_W    = simon_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 increment_i,
  input  logic                 increment_n,
  input  logic                 write_pattern,
  input  logic                 input_led_pattern,
  input  logic [PATTERN_W-1:0] switches,
  output logic                 valid_input,
  output logic                 valid_repeat,
  output logic                 seq_remain,
  output logic [PATTERN_W-1:0] pattern_leds
);

  localparam logic [ADDR_W:0] DepthC = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]      n_q, n_d, i_q, i_d;
  logic [ADDR_W+1:0]    i_plus1;
  logic [PATTERN_W-1:0] rd_data;
  logic                 not_full, i_lt_n, pattern_ok, mem_we;

  assign not_full = (n_q < DepthC);
  assign i_lt_n   = (i_q < n_q);
  assign mem_we   = write_pattern && not_full;

  always_comb begin
    i_d = i_q;
    if (clear_i) begin
      i_d = '0;
    end else if (increment_i && (i_q != DepthC)) begin
      i_d = i_q + 1'b1;
    end
  end

  always_comb begin
    n_d = n_q;
    if (increment_n && not_full) begin
      n_d = n_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q <= '0;
      i_q <= '0;
    end else begin
      n_q <= n_d;
      i_q <= i_d;
    end
  end

  // Write lands at the pre-increment n.
  simon_pattern_mem #(
    .PATTERN_W (PATTERN_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (n_q[ADDR_W-1:0]),
    .wdata (switches),
    .raddr (i_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

`ifdef SIMON_ONEHOT_CHECK_EN
  assign pattern_ok = $onehot(switches);
`else
  assign pattern_ok = |switches;
`endif

  // One extra bit keeps i+1 from overflowing when i sits at DEPTH.
  assign i_plus1 = {1'b0, i_q} + 1'b1;

  assign valid_input  = pattern_ok && not_full;
  assign seq_remain   = (i_plus1 < {1'b0, n_q});
  assign valid_repeat = i_lt_n && (switches == rd_data);
  assign pattern_leds = input_led_pattern ? switches : (i_lt_n ? rd_data : '0);

endmodule

// File: tb/tb_simon_datapath.sv
// Scoreboard bench for simon_datapath: directed stimulus pushes expectations, a monitor checks them.
module tb_simon_datapath;
  import simon_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     clear_i, increment_i, increment_n, write_pattern, input_led_pattern;
  pattern_t switches;
  logic     valid_input, valid_repeat, seq_remain;
  pattern_t pattern_leds;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string    name;
    logic     vi;
    logic     vr;
    logic     sr;
    pattern_t leds;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  simon_datapath dut (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (clear_i),
    .increment_i       (increment_i),
    .increment_n       (increment_n),
    .write_pattern     (write_pattern),
    .input_led_pattern (input_led_pattern),
    .switches          (switches),
    .valid_input       (valid_input),
    .valid_repeat      (valid_repeat),
    .seq_remain        (seq_remain),
    .pattern_leds      (pattern_leds)
  );

`ifdef SIMON_ONEHOT_CHECK_EN
  localparam logic VI_0110 = 1'b0;
`else
  localparam logic VI_0110 = 1'b1;
`endif

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so they are presented every cycle once inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.name, ".valid_input"},  {3'b0, valid_input},  {3'b0, e.vi});
        check({e.name, ".valid_repeat"}, {3'b0, valid_repeat}, {3'b0, e.vr});
        check({e.name, ".seq_remain"},   {3'b0, seq_remain},   {3'b0, e.sr});
        check({e.name, ".pattern_leds"}, pattern_leds,         e.leds);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic clr, input logic inci,
                      input logic incn, input logic wr, input logic ilp, input pattern_t sw,
                      input logic vi, input logic vr, input logic sr, input pattern_t leds);
    exp_t e;
    @(negedge clk);
    rst               = r;
    clear_i           = clr;
    increment_i       = inci;
    increment_n       = incn;
    write_pattern     = wr;
    input_led_pattern = ilp;
    switches          = sw;
    e.name = nm; e.vi = vi; e.vr = vr; e.sr = sr; e.leds = leds;
    exp_q.push_back(e);
  endtask

  initial begin
    pattern_t exp_led;
    int       waited;
    rst = 1'b0; clear_i = 0; increment_i = 0; increment_n = 0;
    write_pattern = 0; input_led_pattern = 0; switches = '0;

    //     name          rst clr inci incn wr ilp sw       vi vr sr leds
    step("reset_lo",     0,  0,  0,   0,   0, 0,  4'b0010, 1, 0, 0, 4'b0000);
    step("reset_ilp",    0,  0,  1,   1,   1, 1,  4'b0010, 1, 0, 0, 4'b0010);
    step("hold0",        1,  0,  0,   0,   0, 0,  4'b0010, 1, 0, 0, 4'b0000);
    step("hold1",        1,  0,  0,   0,   0, 0,  4'b0010, 1, 0, 0, 4'b0000);
    step("wr0",          1,  1,  0,   1,   1, 0,  4'b0001, 1, 0, 0, 4'b0000);
    step("wr1",          1,  1,  0,   1,   1, 0,  4'b0100, 1, 0, 0, 4'b0001);
    step("wr2",          1,  1,  0,   1,   1, 0,  4'b1000, 1, 0, 1, 4'b0001);
    step("play0",        1,  0,  1,   0,   0, 0,  4'b0000, 0, 0, 1, 4'b0001);
    step("play1",        1,  0,  1,   0,   0, 0,  4'b0000, 0, 0, 1, 4'b0100);
    step("play2",        1,  0,  1,   0,   0, 0,  4'b0000, 0, 0, 0, 4'b1000);
    step("i_eq_n",       1,  0,  0,   0,   0, 0,  4'b1000, 1, 0, 0, 4'b0000);
    step("clear",        1,  1,  0,   0,   0, 0,  4'b1000, 1, 0, 0, 4'b0000);
    step("rep_match",    1,  0,  0,   0,   0, 0,  4'b0001, 1, 1, 1, 4'b0001);
    step("rep_miss",     1,  0,  0,   0,   0, 0,  4'b1000, 1, 0, 1, 4'b0001);
    step("ilp_inc",      1,  0,  1,   0,   0, 1,  4'b0100, 1, 0, 1, 4'b0100);
    step("clr_and_inc",  1,  1,  1,   0,   0, 0,  4'b0100, 1, 1, 1, 4'b0100);
    step("clr_priority", 1,  0,  0,   0,   0, 0,  4'b0001, 1, 1, 1, 4'b0001);
    step("sw_0110",      1,  0,  0,   0,   0, 0,  4'b0110, VI_0110, 0, 1, 4'b0001);
    step("sw_0000",      1,  0,  0,   0,   0, 0,  4'b0000, 0, 0, 1, 4'b0001);

    // Fill entries 3..63 with 0010; i stays 0 so mem[0] is on the LEDs.
    for (int k = 3; k < 64; k++) begin
      step("fill",       1,  1,  0,   1,   1, 0,  4'b0010, 1, 0, 1, 4'b0001);
    end
    step("full_vi",      1,  0,  0,   0,   0, 0,  4'b0001, 0, 1, 1, 4'b0001);
    step("wr65",         1,  0,  0,   1,   1, 0,  4'b0100, 0, 0, 1, 4'b0001);
    step("after_wr65",   1,  0,  0,   0,   0, 0,  4'b0001, 0, 1, 1, 4'b0001);

    // Walk i across the full memory, then past the end.
    for (int k = 0; k < 64; k++) begin
      exp_led = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0100 : (k == 2) ? 4'b1000 : 4'b0010;
      step("walk",       1,  0,  1,   0,   0, 0,  4'b0000, 0, 0, (k < 63), exp_led);
    end
    step("i_at_depth",   1,  0,  1,   0,   0, 0,  4'b0010, 0, 0, 0, 4'b0000);
    step("i_sat",        1,  0,  0,   0,   0, 0,  4'b0010, 0, 0, 0, 4'b0000);
    // Asynchronous reset mid-operation, checked before any rising edge.
    step("async_rst",    0,  0,  0,   0,   0, 0,  4'b0001, 1, 0, 0, 4'b0000);
    step("post_rst",     1,  0,  0,   0,   0, 0,  4'b0001, 1, 0, 0, 4'b0000);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
